// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, width codes and alignment rules for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        FIN
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width codes; the unsigned ones are load-only.
    function automatic logic legal_f3(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3 == F3_H || f3 == F3_HU) && lo[0]) || (f3 == F3_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane select/extend and store lane merge (combinational)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        sh       = {lane, 3'b000};
        shifted  = rdata >> sh;
        load_ext = rdata;
        case (funct3)
            F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_ext = {24'h000000, shifted[7:0]};
            F3_HU:   load_ext = {16'h0000, shifted[15:0]};
            default: load_ext = rdata;
        endcase

        // Only the addressed lanes take the new data; the rest keep the read word.
        case (funct3)
            F3_B:    mask = 32'h0000_00FF << sh;
            F3_H:    mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        merged = (rdata & ~mask) | ((wdata << sh) & mask);
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit FSM with read-modify-write sub-word stores
module lsu
    import lsu_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1val,
    input  logic [11:0] imm,
    input  logic [31:0] storeData,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [31:0] loadData,
    output logic        ramR,
    output logic        ramW,
    output logic [31:0] ramAddr,
    output logic [31:0] ramDataW,
    input  logic [31:0] ramDataR
);

    state_t      state, state_nx;
    logic [31:0] ea_d;
    logic        bad_d;
    logic        sw_d;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [31:0] sdata_q;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign ea_d  = rs1val + {{20{imm[11]}}, imm};
    assign bad_d = !legal_f3(isStore, funct3) || misaligned(funct3, ea_d[1:0]);
    assign sw_d  = isStore && funct3 == F3_W;

    lsu_align u_align (
        .funct3   (f3_q),
        .lane     (lane_q),
        .rdata    (ramDataR),
        .wdata    (sdata_q),
        .load_ext (load_ext),
        .merged   (merged)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_d)     state_nx = FIN;
                    else if (sw_d) state_nx = WR;
                    else           state_nx = RD;
                end
            end
            RD:      state_nx = RWAIT;
            RWAIT:   state_nx = st_q ? WR : FIN;
            WR:      state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == FIN);
        ramR  = (state == RD);
        ramW  = (state == WR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_q   <= 2'b00;
            f3_q     <= 3'b000;
            st_q     <= 1'b0;
            sdata_q  <= 32'h0;
            fault    <= 1'b0;
            loadData <= 32'h0;
            ramAddr  <= 32'h0;
            ramDataW <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lane_q  <= ea_d[1:0];
                        f3_q    <= funct3;
                        st_q    <= isStore;
                        sdata_q <= storeData;
                        fault   <= bad_d;
                        ramAddr <= 32'(ea_d[AW+1:2]);
                        if (sw_d) ramDataW <= storeData;
                    end
                end
                RWAIT: begin
                    if (st_q) ramDataW <= merged;
                    else      loadData <= load_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a byte-array reference model
module tb_lsu;

    localparam int AW = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1val = 32'h0;
    logic [11:0] imm = 12'h0;
    logic [31:0] storeData = 32'h0;
    logic        ready, done, fault, ramR, ramW;
    logic [31:0] loadData, ramAddr, ramDataW;
    logic [31:0] ramDataR;

    always #5 clock = ~clock;

    lsu #(.AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .isStore   (isStore),
        .funct3    (funct3),
        .rs1val    (rs1val),
        .imm       (imm),
        .storeData (storeData),
        .ready     (ready),
        .done      (done),
        .fault     (fault),
        .loadData  (loadData),
        .ramR      (ramR),
        .ramW      (ramW),
        .ramAddr   (ramAddr),
        .ramDataW  (ramDataW),
        .ramDataR  (ramDataR)
    );

    logic [31:0] mem [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = 5'd0;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clock) begin
        if (pl_en)     mem[pl_addr] <= pl_data;
        else if (ramW) mem[ramAddr[4:0]] <= ramDataW;
        if (ramR) ramDataR <= mem[ramAddr[4:0]];
    end

    int          total = 0;
    int          bad = 0;
    logic [7:0]  ref_mem [0:127];
    logic [31:0] last_ld = 32'h0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [11:0] imm;
        logic [31:0] sd;
        logic [31:0] eld;
        logic        eflt;
        int          elat;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] r,
                                  input logic [11:0] im, input logic [31:0] sd,
                                  output logic eflt, output int elat, output int erd,
                                  output int ewr, output logic [31:0] eaddr);
        logic [31:0] ea;
        logic [31:0] v;
        int size;
        int b;
        ea = r + {{20{im[11]}}, im};
        b = int'(ea[6:0]);
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (st && f3 > 3'd2) size = 0;
        eaddr = {27'b0, ea[6:2]};
        eflt = (size == 0) ? 1'b1 : (b % size != 0);
        if (eflt) begin
            elat = 1; erd = 0; ewr = 0;
        end else if (st) begin
            for (int i = 0; i < size; i++) ref_mem[b + i] = sd[8*i +: 8];
            elat = (size == 4) ? 2 : 4;
            erd  = (size == 4) ? 0 : 1;
            ewr  = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[b + i]) << (8 * i));
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            last_ld = v;
            elat = 3; erd = 1; ewr = 0;
        end
    endfunction

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] r,
                          input logic [11:0] im, input logic [31:0] sd,
                          output logic [31:0] ld, output logic flt, output int lat,
                          output int nrd, output int nwr, output int nboth,
                          output logic [31:0] aseen);
        int guard;
        guard = 0;
        nrd = 0; nwr = 0; nboth = 0; lat = 0; aseen = 32'h0; ld = 32'h0; flt = 1'b0;
        @(negedge clock);
        while (!ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        isStore = st; funct3 = f3; rs1val = r; imm = im; storeData = sd; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (ramR) nrd++;
            if (ramW) nwr++;
            if (ramR && ramW) nboth++;
            if (ramR || ramW) aseen = ramAddr;
            if (done) begin
                ld = loadData;
                flt = fault;
                break;
            end
        end
        if (!done) lat = 99;
    endtask

    task automatic exec(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] r,
                        input logic [11:0] im, input logic [31:0] sd,
                        output logic [31:0] ld, output logic flt, output int lat);
        int nrd, nwr, nboth, elat, erd, ewr;
        logic [31:0] aseen, eaddr;
        logic eflt;
        run_op(st, f3, r, im, sd, ld, flt, lat, nrd, nwr, nboth, aseen);
        model(st, f3, r, im, sd, eflt, elat, erd, ewr, eaddr);
        chk({nm, ".fault"}, 32'(flt), 32'(eflt));
        chk({nm, ".latency"}, lat, elat);
        chk({nm, ".loadData"}, ld, last_ld);
        chk({nm, ".ramR_cycles"}, nrd, erd);
        chk({nm, ".ramW_cycles"}, nwr, ewr);
        chk({nm, ".both_enables"}, nboth, 0);
        if (erd + ewr > 0) chk({nm, ".ramAddr"}, aseen, eaddr);
    endtask

    initial begin
        logic [31:0] w, ld, eaddr;
        logic flt, eflt;
        int lat, elat, erd, ewr, dcnt, nw;
        logic [2:0] f3;
        logic st;

        for (int i = 0; i < 32; i++) begin
            w = (i == 6) ? 32'h000F_4240 : $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
            @(negedge clock);
            pl_en = 1'b1; pl_addr = 5'(i); pl_data = w;
        end
        @(negedge clock);
        pl_en = 1'b0;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.loadData", loadData, 32'h0);
        chk("rst.ramR", 32'(ramR), 32'd0);
        chk("rst.ramW", 32'(ramW), 32'd0);
        chk("rst.ramAddr", ramAddr, 32'h0);
        chk("rst.ramDataW", ramDataW, 32'h0);
        reset = 1'b0;

        vt[0]  = '{1'b0, 3'b010, 32'h10,       12'h008, 32'h0,         32'h000F_4240, 1'b0, 3};
        vt[1]  = '{1'b0, 3'b000, 32'h19,       12'h000, 32'h0,         32'h0000_0042, 1'b0, 3};
        vt[2]  = '{1'b0, 3'b101, 32'h1A,       12'h000, 32'h0,         32'h0000_000F, 1'b0, 3};
        vt[3]  = '{1'b0, 3'b010, 32'h20,       12'hFF8, 32'h0,         32'h000F_4240, 1'b0, 3};
        vt[4]  = '{1'b1, 3'b000, 32'h1B,       12'h000, 32'h1234_5680, 32'h000F_4240, 1'b0, 4};
        vt[5]  = '{1'b0, 3'b010, 32'h18,       12'h000, 32'h0,         32'h800F_4240, 1'b0, 3};
        vt[6]  = '{1'b0, 3'b000, 32'h1B,       12'h000, 32'h0,         32'hFFFF_FF80, 1'b0, 3};
        vt[7]  = '{1'b0, 3'b100, 32'h1B,       12'h000, 32'h0,         32'h0000_0080, 1'b0, 3};
        vt[8]  = '{1'b1, 3'b010, 32'h0C,       12'h000, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0, 2};
        vt[9]  = '{1'b0, 3'b010, 32'h0C,       12'h000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        vt[10] = '{1'b0, 3'b010, 32'h19,       12'h000, 32'h0,         32'hDEAD_BEEF, 1'b1, 1};
        vt[11] = '{1'b0, 3'b011, 32'h18,       12'h000, 32'h0,         32'hDEAD_BEEF, 1'b1, 1};
        vt[12] = '{1'b1, 3'b001, 32'h0D,       12'h000, 32'h0000_1111, 32'hDEAD_BEEF, 1'b1, 1};
        vt[13] = '{1'b1, 3'b100, 32'h10,       12'h000, 32'h0000_2222, 32'hDEAD_BEEF, 1'b1, 1};
        vt[14] = '{1'b0, 3'b001, 32'h0E,       12'h000, 32'h0,         32'hFFFF_DEAD, 1'b0, 3};
        vt[15] = '{1'b1, 3'b001, 32'h0E,       12'h000, 32'h5555_CAFE, 32'hFFFF_DEAD, 1'b0, 4};
        vt[16] = '{1'b0, 3'b010, 32'h98,       12'h000, 32'h0,         32'h800F_4240, 1'b0, 3};
        vt[17] = '{1'b0, 3'b010, 32'hFFFF_FFFC, 12'h010, 32'h0,        32'hCAFE_BEEF, 1'b0, 3};

        for (int i = 0; i < 18; i++) begin
            exec($sformatf("vec%0d", i), vt[i].st, vt[i].f3, vt[i].rs1, vt[i].imm, vt[i].sd, ld, flt, lat);
            chk($sformatf("vec%0d.tbl_fault", i), 32'(flt), 32'(vt[i].eflt));
            chk($sformatf("vec%0d.tbl_load", i), ld, vt[i].eld);
            chk($sformatf("vec%0d.tbl_lat", i), lat, vt[i].elat);
        end

        // Reset during the RWAIT cycle of an SH: write must be abandoned.
        @(negedge clock);
        isStore = 1'b1; funct3 = 3'b001; rs1val = 32'h10; imm = 12'h0; storeData = 32'h0000_AAAA;
        req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        chk("rmw_rst.rd_cycle", 32'(ramR), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rmw_rst.ready", 32'(ready), 32'd1);
        chk("rmw_rst.done", 32'(done), 32'd0);
        chk("rmw_rst.fault", 32'(fault), 32'd0);
        chk("rmw_rst.loadData", loadData, 32'h0);
        chk("rmw_rst.ramR", 32'(ramR), 32'd0);
        chk("rmw_rst.ramW", 32'(ramW), 32'd0);
        chk("rmw_rst.ramAddr", ramAddr, 32'h0);
        chk("rmw_rst.ramDataW", ramDataW, 32'h0);
        reset = 1'b0;
        last_ld = 32'h0;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ramW) nw++;
        end
        chk("rmw_rst.no_write", nw, 0);
        chk("rmw_rst.word4", mem[4], {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});

        // req held high (with changing operands) while busy: one done, original address.
        model(1'b0, 3'b010, 32'h0C, 12'h0, 32'h0, eflt, elat, erd, ewr, eaddr);
        @(negedge clock);
        isStore = 1'b0; funct3 = 3'b010; rs1val = 32'h0C; imm = 12'h0; req = 1'b1;
        @(posedge clock);
        #1 rs1val = 32'h18;
        dcnt = 0; lat = 0; ld = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat = i + 1;
                    ld = loadData;
                end
                req = 1'b0;
            end
        end
        req = 1'b0;
        chk("busy_req.done_count", dcnt, 1);
        chk("busy_req.latency", lat, 3);
        chk("busy_req.loadData", ld, last_ld);

        for (int n = 0; n < 200; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            exec($sformatf("rnd%0d", n), st, f3, $urandom, 12'($urandom), $urandom, ld, flt, lat);
        end

        for (int i = 0; i < 32; i++)
            chk($sformatf("mem%0d", i), mem[i],
                {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
